// File: rtl/pu_or1k_store_buffer_drain.sv
// rtl/pu_or1k_store_buffer_drain.sv - store buffer drain into single Wishbone classic write cycles
module pu_or1k_store_buffer_drain #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              drain_en_i,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic                              sb_atomic_i,
    input  logic                              atomic_ok_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
    output logic                              wbm_we_o,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              atomic_fail_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BUS   = 2'd2
    } state_t;

    state_t                          state;
    logic [31:0]                     to_cnt;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_q;
    logic                            timeout_hit;

    // Pop only from IDLE so the popped entry always lands in FETCH the next cycle.
    assign sb_read_o = (state == IDLE) && !sb_empty_i && drain_en_i;

    // A same-cycle ack on the last allowed cycle still completes the store.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (to_cnt == 32'(TIMEOUT_CYCLES - 1)) && !wbm_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy_o          <= 1'b0;
            wbm_cyc_o       <= 1'b0;
            wbm_stb_o       <= 1'b0;
            wbm_we_o        <= 1'b0;
            wbm_adr_o       <= '0;
            wbm_dat_o       <= '0;
            wbm_sel_o       <= '0;
            pc_q            <= '0;
            to_cnt          <= '0;
            done_o          <= 1'b0;
            atomic_fail_o   <= 1'b0;
            store_err_o     <= 1'b0;
            store_err_adr_o <= '0;
            store_err_pc_o  <= '0;
        end else begin
            done_o        <= 1'b0;
            atomic_fail_o <= 1'b0;
            store_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sb_read_o) begin
                        state  <= FETCH;
                        busy_o <= 1'b1;
                    end
                end
                FETCH: begin
                    pc_q <= sb_pc_i;
                    if (sb_atomic_i && !atomic_ok_i) begin
                        state         <= IDLE;
                        busy_o        <= 1'b0;
                        atomic_fail_o <= 1'b1;
                    end else begin
                        state     <= BUS;
                        wbm_adr_o <= sb_adr_i;
                        wbm_dat_o <= sb_dat_i;
                        wbm_sel_o <= sb_bsel_i;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        to_cnt    <= '0;
                    end
                end
                BUS: begin
                    if (wbm_err_i || timeout_hit) begin
                        state           <= IDLE;
                        busy_o          <= 1'b0;
                        wbm_cyc_o       <= 1'b0;
                        wbm_stb_o       <= 1'b0;
                        wbm_we_o        <= 1'b0;
                        store_err_o     <= 1'b1;
                        store_err_adr_o <= wbm_adr_o;
                        store_err_pc_o  <= pc_q;
                    end else if (wbm_ack_i) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_or1k_store_buffer_drain.sv
// tb/tb_pu_or1k_store_buffer_drain.sv - self-checking bench with schedule-based reference model
module tb_pu_or1k_store_buffer_drain;
    localparam int W  = 32;
    localparam int TO = 8;
    localparam int N  = 64;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] pc;
        logic        atomic;
    } entry_t;

    // kind: 0 ack, 1 err, 2 ack+err together, 3 never respond; d = BUS cycle index of response
    typedef struct {
        int kind;
        int d;
    } plan_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         drain_en_i, sb_empty_i, sb_read_o;
    logic [W-1:0] sb_adr_i, sb_dat_i, sb_pc_i;
    logic [3:0]   sb_bsel_i;
    logic         sb_atomic_i, atomic_ok_i;
    logic [W-1:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]   wbm_sel_o;
    logic         wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
    logic         busy_o, done_o, atomic_fail_o, store_err_o;
    logic [W-1:0] store_err_adr_o, store_err_pc_o;

    pu_or1k_store_buffer_drain #(
        .OPTION_OPERAND_WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .drain_en_i(drain_en_i), .sb_empty_i(sb_empty_i), .sb_read_o(sb_read_o),
        .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i),
        .sb_pc_i(sb_pc_i), .sb_atomic_i(sb_atomic_i), .atomic_ok_i(atomic_ok_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .busy_o(busy_o), .done_o(done_o), .atomic_fail_o(atomic_fail_o),
        .store_err_o(store_err_o), .store_err_adr_o(store_err_adr_o),
        .store_err_pc_o(store_err_pc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    entry_t sbq[$];
    plan_t  forced[$];
    plan_t  active[$];
    bit     rand_mode = 0;
    bit     rd_neg = 0;

    // Expected-output timeline, indexed by cycle modulo N.
    bit          e_busy[N], e_cyc[N], e_done[N], e_af[N], e_err[N], e_eset[N];
    logic [31:0] e_adr[N], e_dat[N], e_eadr[N], e_epc[N];
    logic [3:0]  e_sel[N];
    logic [31:0] m_eadr = '0, m_epc = '0;
    int          cyc_n = 0;
    int          fetch_at = -1;
    bit          armed = 0;

    int mon_rd = 0, mon_cychi = 0, mon_done = 0, mon_af = 0, mon_err = 0;
    int last_rd_c = 0;
    bit mon_prev_cyc = 0;
    int          rise_cyc[$];
    logic [31:0] rise_adr[$];

    function automatic void clr(input int s);
        e_busy[s] = 0; e_cyc[s] = 0; e_done[s] = 0; e_af[s] = 0; e_err[s] = 0; e_eset[s] = 0;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        int r;
        r = $urandom_range(0, 15);
        p.kind = (r < 10) ? 0 : (r < 12) ? 1 : (r < 14) ? 2 : 3;
        p.d = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 2);
        return p;
    endfunction

    always @(negedge clk) begin
        int s, t, k;
        bit exp_rd, is_err;
        plan_t p;
        s = cyc_n % N;
        exp_rd = 0;
        if (!armed) begin
            if (rst === 1'b1) armed = 1;
        end else begin
            if (e_eset[s]) begin
                m_eadr = e_eadr[s];
                m_epc  = e_epc[s];
            end
            check("busy", busy_o, e_busy[s]);
            check("cyc", wbm_cyc_o, e_cyc[s]);
            check("stb", wbm_stb_o, e_cyc[s]);
            check("we", wbm_we_o, e_cyc[s]);
            check("done", done_o, e_done[s]);
            check("atomic_fail", atomic_fail_o, e_af[s]);
            check("store_err", store_err_o, e_err[s]);
            check("err_adr", store_err_adr_o, m_eadr);
            check("err_pc", store_err_pc_o, m_epc);
            if (e_cyc[s]) begin
                check("wbm_adr", wbm_adr_o, e_adr[s]);
                check("wbm_dat", wbm_dat_o, e_dat[s]);
                check("wbm_sel", wbm_sel_o, e_sel[s]);
            end
            if (!rst) begin
                exp_rd = !e_busy[s] && !sb_empty_i && drain_en_i;
                check("sb_read", sb_read_o, exp_rd);
            end
            mon_rd    += sb_read_o ? 1 : 0;
            mon_cychi += wbm_cyc_o ? 1 : 0;
            mon_done  += done_o ? 1 : 0;
            mon_af    += atomic_fail_o ? 1 : 0;
            mon_err   += store_err_o ? 1 : 0;
            if (sb_read_o) last_rd_c = cyc_n;
            if (wbm_cyc_o && !mon_prev_cyc) begin
                rise_cyc.push_back(cyc_n);
                rise_adr.push_back(wbm_adr_o);
            end
            mon_prev_cyc = wbm_cyc_o;
        end
        rd_neg = (sb_read_o === 1'b1) && (rst === 1'b0);
        if (armed) begin
            if (rst) begin
                for (int j = 1; j <= 15; j++) clr((cyc_n + j) % N);
                fetch_at = -1;
                t = (cyc_n + 1) % N;
                e_eset[t] = 1; e_eadr[t] = '0; e_epc[t] = '0;
            end else begin
                if (cyc_n == fetch_at) begin
                    if (sb_atomic_i && !atomic_ok_i) begin
                        e_af[(cyc_n + 1) % N] = 1;
                    end else begin
                        if (forced.size() > 0) p = forced.pop_front();
                        else p = rand_plan();
                        active.push_back(p);
                        if (p.kind == 3 || p.d > TO - 1) begin
                            k = TO - 1; is_err = 1;
                        end else begin
                            k = p.d; is_err = (p.kind != 0);
                        end
                        for (int j = 1; j <= k + 1; j++) begin
                            t = (cyc_n + j) % N;
                            e_busy[t] = 1; e_cyc[t] = 1;
                            e_adr[t] = sb_adr_i; e_dat[t] = sb_dat_i; e_sel[t] = sb_bsel_i;
                        end
                        t = (cyc_n + k + 2) % N;
                        if (is_err) begin
                            e_err[t] = 1; e_eset[t] = 1; e_eadr[t] = sb_adr_i; e_epc[t] = sb_pc_i;
                        end else begin
                            e_done[t] = 1;
                        end
                    end
                end
                if (exp_rd) begin
                    e_busy[(cyc_n + 1) % N] = 1;
                    fetch_at = cyc_n + 1;
                end
            end
        end
        clr(s);
        cyc_n++;
    end

    plan_t cur;
    bit    have_plan = 0;
    bit    prev_cyc = 0;
    int    bus_cnt = 0;

    task automatic push_entry(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                              input logic [31:0] pc, input logic atomic);
        entry_t e;
        e.adr = adr; e.dat = dat; e.sel = sel; e.pc = pc; e.atomic = atomic;
        sbq.push_back(e);
        sb_empty_i = 1'b0;
    endtask

    task automatic tick();
        entry_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            active.delete();
            have_plan = 0;
            prev_cyc = 0;
            wbm_ack_i = 0;
            wbm_err_i = 0;
        end else begin
            if (rd_neg && sbq.size() > 0) begin
                e = sbq.pop_front();
                sb_adr_i = e.adr; sb_dat_i = e.dat; sb_bsel_i = e.sel;
                sb_pc_i = e.pc; sb_atomic_i = e.atomic;
            end else begin
                sb_adr_i = $urandom; sb_dat_i = $urandom; sb_bsel_i = 4'($urandom);
                sb_pc_i = $urandom; sb_atomic_i = 1'($urandom);
            end
            if (wbm_cyc_o && !prev_cyc) begin
                have_plan = (active.size() > 0);
                if (have_plan) cur = active.pop_front();
                bus_cnt = 0;
            end else if (wbm_cyc_o) begin
                bus_cnt++;
            end
            prev_cyc = wbm_cyc_o;
            wbm_ack_i = wbm_cyc_o && have_plan && (cur.kind == 0 || cur.kind == 2) && (bus_cnt == cur.d);
            wbm_err_i = wbm_cyc_o && have_plan && (cur.kind == 1 || cur.kind == 2) && (bus_cnt == cur.d);
        end
        if (rand_mode) begin
            drain_en_i  = ($urandom_range(0, 3) != 0);
            atomic_ok_i = 1'($urandom);
            if (sbq.size() < 6 && $urandom_range(0, 2) == 0)
                push_entry($urandom, $urandom, 4'($urandom), $urandom, ($urandom_range(0, 4) == 0));
        end
        sb_empty_i = (sbq.size() == 0);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((sbq.size() != 0 || busy_o) && n < max);
        if (n >= max) check("wait_idle_timeout", 1, 0);
        repeat (2) tick();
    endtask

    task automatic wait_cyc(input int max);
        int n;
        n = 0;
        while (!wbm_cyc_o && n < max) begin
            tick();
            n++;
        end
        if (n >= max) check("wait_cyc_timeout", 1, 0);
    endtask

    initial begin
        int b_rd, b_cyc, b_done, b_af, b_err, b_rise;
        rst = 1; drain_en_i = 1; sb_empty_i = 1; atomic_ok_i = 1;
        sb_adr_i = '0; sb_dat_i = '0; sb_bsel_i = '0; sb_pc_i = '0; sb_atomic_i = 0;
        wbm_ack_i = 0; wbm_err_i = 0;
        repeat (3) tick();
        rst = 0;
        tick();

        check("reset_ctrl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, atomic_fail_o, store_err_o, sb_read_o}, 0);
        check("reset_adr", wbm_adr_o, 0);
        check("reset_dat", wbm_dat_o, 0);
        check("reset_sel", wbm_sel_o, 0);
        check("reset_err_adr", store_err_adr_o, 0);
        check("reset_err_pc", store_err_pc_o, 0);

        // single store, ack on first BUS cycle
        b_rd = mon_rd; b_cyc = mon_cychi; b_done = mon_done;
        forced.push_back('{0, 0});
        push_entry(32'h1000, 32'hDEADBEEF, 4'hF, 32'h200, 0);
        wait_idle(50);
        check("single_rd_count", mon_rd - b_rd, 1);
        check("single_cyc_cycles", mon_cychi - b_cyc, 1);
        check("single_done", mon_done - b_done, 1);
        check("single_adr", rise_adr[rise_adr.size() - 1], 32'h1000);
        check("single_latency", rise_cyc[rise_cyc.size() - 1] - last_rd_c, 2);

        // back-to-back, ack delayed 2 cycles
        drain_en_i = 0;
        tick();
        b_rd = mon_rd; b_cyc = mon_cychi; b_done = mon_done; b_rise = rise_cyc.size();
        for (int i = 0; i < 4; i++) begin
            forced.push_back('{0, 2});
            push_entry(32'h1100 + 32'(16 * i), 32'hA0 + 32'(i), 4'(i + 1), 32'h400 + 32'(4 * i), 0);
        end
        drain_en_i = 1;
        wait_idle(100);
        check("b2b_rd_count", mon_rd - b_rd, 4);
        check("b2b_cyc_cycles", mon_cychi - b_cyc, 12);
        check("b2b_done", mon_done - b_done, 4);
        check("b2b_writes", rise_cyc.size() - b_rise, 4);
        if (rise_cyc.size() - b_rise == 4) begin
            for (int i = 0; i < 4; i++) check("b2b_order", rise_adr[b_rise + i], 32'h1100 + 32'(16 * i));
            for (int i = 1; i < 4; i++) check("b2b_spacing", rise_cyc[b_rise + i] - rise_cyc[b_rise + i - 1], 5);
        end

        // atomic reservation lost
        drain_en_i = 0; atomic_ok_i = 0;
        tick();
        b_af = mon_af; b_done = mon_done; b_rise = rise_cyc.size();
        forced.push_back('{0, 0});
        push_entry(32'h3000, 32'h11, 4'hF, 32'h600, 1);
        push_entry(32'h3100, 32'h22, 4'h3, 32'h604, 0);
        drain_en_i = 1;
        wait_idle(50);
        atomic_ok_i = 1;
        check("atomic_fail_pulse", mon_af - b_af, 1);
        check("atomic_writes", rise_cyc.size() - b_rise, 1);
        check("atomic_next_adr", rise_adr[rise_adr.size() - 1], 32'h3100);
        check("atomic_next_done", mon_done - b_done, 1);

        // ack and err together: err wins
        b_err = mon_err; b_done = mon_done;
        forced.push_back('{2, 0});
        push_entry(32'h2000, 32'h33, 4'hC, 32'h300, 0);
        wait_idle(50);
        check("buserr_pulse", mon_err - b_err, 1);
        check("buserr_no_done", mon_done - b_done, 0);
        check("buserr_adr", store_err_adr_o, 32'h2000);
        check("buserr_pc", store_err_pc_o, 32'h300);
        repeat (5) tick();
        check("buserr_adr_held", store_err_adr_o, 32'h2000);
        check("buserr_pc_held", store_err_pc_o, 32'h300);

        // timeout with drain_en dropped mid-BUS
        b_err = mon_err; b_cyc = mon_cychi;
        forced.push_back('{3, 99});
        push_entry(32'h5000, 32'h44, 4'hF, 32'h500, 0);
        wait_cyc(20);
        drain_en_i = 0;
        repeat (3) tick();
        drain_en_i = 1;
        wait_idle(50);
        check("timeout_cyc_cycles", mon_cychi - b_cyc, 8);
        check("timeout_err", mon_err - b_err, 1);
        check("timeout_err_adr", store_err_adr_o, 32'h5000);

        // reset while the bus cycle is open
        forced.push_back('{3, 99});
        push_entry(32'h4000, 32'h55, 4'hF, 32'h700, 0);
        wait_cyc(20);
        repeat (2) tick();
        b_err = mon_err; b_done = mon_done;
        rst = 1;
        tick();
        check("rst_mid_cyc", wbm_cyc_o, 0);
        check("rst_mid_stb", wbm_stb_o, 0);
        check("rst_mid_busy", busy_o, 0);
        rst = 0;
        repeat (12) tick();
        check("rst_mid_no_done", mon_done - b_done, 0);
        check("rst_mid_no_err", mon_err - b_err, 0);
        check("rst_mid_err_adr", store_err_adr_o, 0);

        // randomized traffic against the model
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        drain_en_i = 1;
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pu_or1k_store_buffer_drain.md
Name: pu_or1k_store_buffer_drain

Overview:
- Read side of the LSU store buffer FIFO.
- Pops one buffered store at a time and issues it as a single Wishbone classic write cycle (no bursts).
- Checks the atomic (store-conditional) reservation before the bus access.
- Reports bus errors and timeouts with the faulting address and PC.
- Sits between the store buffer and the data-bus arbiter.

Parameters:
- OPTION_OPERAND_WIDTH, 32: address/data width; byte-select width is OPTION_OPERAND_WIDTH/8.
- TIMEOUT_CYCLES, 0: maximum bus cycles without ack/err before a timeout is declared; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- drain_en_i  in  1  permission to start a new drain; low stalls the pop but never aborts an in-flight write
- sb_empty_i  in  1  store buffer empty
- sb_read_o  out  1  pop strobe to store buffer; entry data is valid on sb_* the cycle after
- sb_adr_i  in  OPTION_OPERAND_WIDTH  popped store address
- sb_dat_i  in  OPTION_OPERAND_WIDTH  popped store data
- sb_bsel_i  in  OPTION_OPERAND_WIDTH/8  popped byte selects
- sb_pc_i  in  OPTION_OPERAND_WIDTH  PC of popped store
- sb_atomic_i  in  1  popped store is store-conditional
- atomic_ok_i  in  1  reservation still valid, sampled in FETCH
- wbm_adr_o  out  OPTION_OPERAND_WIDTH  bus address
- wbm_dat_o  out  OPTION_OPERAND_WIDTH  bus write data
- wbm_sel_o  out  OPTION_OPERAND_WIDTH/8  bus byte selects
- wbm_we_o  out  1  write enable, high whenever cyc is high
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  bus acknowledge
- wbm_err_i  in  1  bus error
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse: store completed (acked)
- atomic_fail_o  out  1  one-cycle pulse: atomic store discarded
- store_err_o  out  1  one-cycle pulse: bus error or timeout
- store_err_adr_o  out  OPTION_OPERAND_WIDTH  address of last failed store, held until next error
- store_err_pc_o  out  OPTION_OPERAND_WIDTH  PC of last failed store, held until next error

Behaviour:
- Reset values (synchronous, active-high):
  - State = IDLE.
  - wbm_cyc/stb/we, done, atomic_fail, store_err = 0.
  - wbm_adr/dat/sel, store_err_adr/pc, timeout counter = 0.
- Reset mid-cycle: cyc/stb drop at that edge. The latched entry is discarded and no pulse is issued.
- Output timing:
  - sb_read_o is combinational: (state==IDLE) && !sb_empty_i && drain_en_i.
  - All other outputs are registered.
- States:
  - IDLE:
    - If sb_read_o: go to FETCH.
    - Otherwise stay.
  - FETCH:
    - Latch sb_adr/dat/bsel/pc/atomic into internal registers.
    - If sb_atomic_i && !atomic_ok_i: go to IDLE and pulse atomic_fail_o next cycle; no bus access.
    - Otherwise: go to BUS; set cyc=stb=we=1 and drive wbm_adr/dat/sel from the latched values at this edge.
    - sb_read_o is never high in FETCH.
  - BUS:
    - cyc/stb/adr/dat/sel stay stable until termination.
    - The timeout counter increments each BUS cycle.
    - wbm_err_i, or timeout (TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1 with no ack): clear cyc/stb/we, capture store_err_adr_o/pc_o, pulse store_err_o, go to IDLE.
    - wbm_ack_i (no err): clear cyc/stb/we, pulse done_o, go to IDLE.
    - ack and err in the same cycle: err wins; no done_o.
    - The counter clears on entry to BUS.
- Throughput:
  - Minimum 3 cycles per store (IDLE pop, FETCH, BUS with same-cycle ack).
  - cyc deasserts for at least one cycle between stores.
- drain_en_i deasserted during FETCH/BUS has no effect on the in-flight store.
- Empty buffer: stay in IDLE with sb_read_o=0. sb_empty_i is only sampled in IDLE.
- Store order is FIFO order. No coalescing; exactly one bus write per non-discarded entry.
- A bus error does not block further drains; software or the exception unit reacts to store_err_o.

Test Plan:
- Single store: push adr=0x1000, dat=0xDEADBEEF, bsel=0xF, pc=0x200, ack on first BUS cycle.
  - sb_read_o high 1 cycle.
  - cyc/stb high exactly 1 cycle 2 cycles later, with matching adr/dat/sel.
  - done_o pulses once.
- Back-to-back: 4 entries queued, ack delayed 2 cycles each.
  - 4 writes in FIFO order, 5 cycles each.
  - cyc low ≥1 cycle between writes.
  - sb_read_o count = 4.
- Atomic fail: entry atomic=1 with atomic_ok_i=0 at FETCH.
  - No cyc assertion.
  - atomic_fail_o pulses.
  - Next entry (atomic=0) written normally.
- Bus error: wbm_err_i and wbm_ack_i both high on entry adr=0x2000, pc=0x300.
  - store_err_o pulses; no done_o.
  - store_err_adr_o=0x2000 and store_err_pc_o=0x300, held.
- Timeout: TIMEOUT_CYCLES=8, no ack or err.
  - cyc drops after exactly 8 BUS cycles; store_err_o pulses.
  - drain_en_i toggled low mid-BUS does not shorten this.
- Reset mid-BUS: rst high 1 cycle while cyc=1.
  - cyc/stb=0 the next cycle; no done/err pulse; state IDLE.
